dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the 64-bit data memory (`dmem`) of the vector processor. It shares the memory between the vector load/store unit (requester 0, which issues bursts of 1–8 consecutive words) and the scalar/loader port (requester 1, which issues single words). It generates per-cycle memory commands and returns read data with fixed latency.

---
 rtl/dmem_arbiter_if.sv | 49 ++++
 rtl/dmem_arbiter.sv | 158 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : dmem_arbiter_if                                        |
// | Brief   : Requester, response and memory-command bundle for the  |
// |           two-port dmem arbiter.                                 |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface dmem_arbiter_if;
  logic        r0_req;
  logic        r0_we;
  logic [14:0] r0_addr;
  logic [2:0]  r0_len;
  logic [63:0] r0_wdata;
  logic        r0_gnt;
  logic        r0_beat;
  logic        r1_req;
  logic        r1_we;
  logic [14:0] r1_addr;
  logic [63:0] r1_wdata;
  logic        r1_gnt;
  logic        r0_rvalid;
  logic        r1_rvalid;
  logic [63:0] rdata;
  logic        rsp_err;
  logic [14:0] mem_dir;
  logic        mem_write_flag;
  logic        mem_file_enable;
  logic [63:0] mem_data_in;
  logic [63:0] mem_data_out;

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_len, r0_wdata,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    input  mem_data_out,
    output r0_gnt, r0_beat, r1_gnt,
    output r0_rvalid, r1_rvalid, rdata, rsp_err,
    output mem_dir, mem_write_flag, mem_file_enable, mem_data_in
  );

  modport master (
    output r0_req, r0_we, r0_addr, r0_len, r0_wdata,
    output r1_req, r1_we, r1_addr, r1_wdata,
    output mem_data_out,
    input  r0_gnt, r0_beat, r1_gnt,
    input  r0_rvalid, r1_rvalid, rdata, rsp_err,
    input  mem_dir, mem_write_flag, mem_file_enable, mem_data_in
  );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : dmem_arbiter                                           |
// | Brief   : Two-port dmem arbiter/sequencer (vector bursts, scalar |
// |           singles), 2-cycle read return. Optional out-of-range   |
// |           checking via macro DMEM_ARB_BOUNDS_EN.                 |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module dmem_arbiter #(
  parameter int MEM_TOP = 24576
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_last, w_last_nxt;
  logic        r_we, w_we_nxt;
  logic [2:0]  r_len, w_len_nxt;
  logic [2:0]  r_cnt, w_cnt_nxt;
  logic [14:0] r_addr, w_addr_nxt;

  logic        w_pick0;
  logic        w_gnt0, w_gnt1;
  logic        w_beat, w_beat_we, w_beat_id, w_beat_err;
  logic [14:0] w_beat_addr;
  logic [63:0] w_beat_data;

  logic [14:0] r_mem_dir;
  logic        r_mem_wr;
  logic [63:0] r_mem_din;
  logic        r_p1_valid, r_p1_id, r_p1_err;
  logic        r_p2_valid, r_p2_id, r_p2_err;

  // On a tie the requester that did not win last time goes first.
  assign w_pick0 = bus.r0_req && (!bus.r1_req || r_last);

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_we_nxt    = r_we;
    w_len_nxt   = r_len;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr;
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_beat      = 1'b0;
    w_beat_we   = 1'b0;
    w_beat_id   = 1'b0;
    w_beat_addr = r_addr;
    w_beat_data = bus.r0_wdata;
    case (r_state)
      ST_IDLE: begin
        if (w_pick0) begin
          w_gnt0      = 1'b1;
          w_beat      = 1'b1;
          w_beat_we   = bus.r0_we;
          w_beat_addr = bus.r0_addr;
          w_beat_data = bus.r0_wdata;
          w_we_nxt    = bus.r0_we;
          w_len_nxt   = bus.r0_len;
          w_cnt_nxt   = 3'd1;
          w_addr_nxt  = bus.r0_addr;
          w_last_nxt  = 1'b0;
          if (bus.r0_len != 3'd0) begin
            w_state_nxt = ST_BURST;
          end
        end else if (bus.r1_req) begin
          w_gnt1      = 1'b1;
          w_beat      = 1'b1;
          w_beat_we   = bus.r1_we;
          w_beat_id   = 1'b1;
          w_beat_addr = bus.r1_addr;
          w_beat_data = bus.r1_wdata;
          w_last_nxt  = 1'b1;
        end
      end
      ST_BURST: begin
        w_beat      = 1'b1;
        w_beat_we   = r_we;
        w_beat_addr = r_addr + 15'd1;
        w_beat_data = bus.r0_wdata;
        w_addr_nxt  = w_beat_addr;
        w_cnt_nxt   = r_cnt + 3'd1;
        if (r_cnt == r_len) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef DMEM_ARB_BOUNDS_EN
  localparam logic [14:0] c_mem_top = 15'(MEM_TOP);
  assign w_beat_err = (w_beat_addr > c_mem_top);
`else
  assign w_beat_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_last     <= 1'b1;
      r_we       <= 1'b0;
      r_len      <= 3'd0;
      r_cnt      <= 3'd0;
      r_addr     <= 15'd0;
      r_mem_dir  <= 15'd0;
      r_mem_wr   <= 1'b0;
      r_mem_din  <= 64'd0;
      r_p1_valid <= 1'b0;
      r_p1_id    <= 1'b0;
      r_p1_err   <= 1'b0;
      r_p2_valid <= 1'b0;
      r_p2_id    <= 1'b0;
      r_p2_err   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_last     <= w_last_nxt;
      r_we       <= w_we_nxt;
      r_len      <= w_len_nxt;
      r_cnt      <= w_cnt_nxt;
      r_addr     <= w_addr_nxt;
      r_mem_wr   <= w_beat && w_beat_we && !w_beat_err;
      if (w_beat) begin
        r_mem_dir <= w_beat_addr;
        r_mem_din <= w_beat_data;
      end
      // Flagged reads keep their slot so the response order stays intact.
      r_p1_valid <= w_beat && !w_beat_we;
      r_p1_id    <= w_beat_id;
      r_p1_err   <= w_beat_err;
      r_p2_valid <= r_p1_valid;
      r_p2_id    <= r_p1_id;
      r_p2_err   <= r_p1_err;
    end
  end

  assign bus.r0_gnt          = w_gnt0 && !rst;
  assign bus.r1_gnt          = w_gnt1 && !rst;
  assign bus.r0_beat         = w_beat && !w_beat_id && !rst;
  assign bus.r0_rvalid       = r_p2_valid && !r_p2_id;
  assign bus.r1_rvalid       = r_p2_valid && r_p2_id;
  assign bus.rsp_err         = r_p2_valid && r_p2_err;
  assign bus.rdata           = (r_p2_valid && !r_p2_err) ? bus.mem_data_out : 64'd0;
  assign bus.mem_dir         = r_mem_dir;
  assign bus.mem_write_flag  = r_mem_wr;
  assign bus.mem_file_enable = 1'b0;
  assign bus.mem_data_in     = r_mem_din;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_dmem_arbiter                                        |
// | Brief   : Directed scoreboard bench for dmem_arbiter with a      |
// |           behavioural 2-cycle-latency memory.                    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_dmem_arbiter;
  localparam int MEM_TOP = 24576;

  typedef struct packed {
    logic        id;
    logic [63:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t mon_e;

  logic [63:0] mem    [0:32767];
  logic [63:0] shadow [0:32767];
  bit          mem_ready;

  dmem_arbiter_if bus();

  dmem_arbiter #(.MEM_TOP(MEM_TOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] init_val(input int i);
    return 64'hC0DE_0000_0000_0000 | 64'(i);
  endfunction

  function automatic logic oob(input logic [14:0] a);
`ifdef DMEM_ARB_BOUNDS_EN
    return int'(a) > MEM_TOP;
`else
    return (a != a);
`endif
  endfunction

  // Memory: write lands on the falling edge, read is sampled on the rising edge.
  always @(negedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 32768; i++) mem[i] = init_val(i);
      mem[5] = 64'hA5;
      mem_ready = 1'b1;
    end else if (bus.mem_write_flag) begin
      mem[bus.mem_dir] = bus.mem_data_in;
    end
  end
  always @(posedge clk) bus.mem_data_out <= mem[bus.mem_dir];

  always @(negedge clk) begin
    if (bus.r0_rvalid || bus.r1_rvalid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: cyc %0d r0_rvalid %0b r1_rvalid %0b rdata %0h, required no response",
                 cyc, bus.r0_rvalid, bus.r1_rvalid, bus.rdata);
      end else begin
        mon_e = q.pop_front();
        if (bus.r0_rvalid !== !mon_e.id || bus.r1_rvalid !== mon_e.id ||
            bus.rdata !== mon_e.data || bus.rsp_err !== mon_e.err || cyc != mon_e.cyc) begin
          errors++;
          $display("FAIL rsp: got cyc %0d r0v %0b r1v %0b rdata %0h err %0b, required cyc %0d id %0b rdata %0h err %0b",
                   cyc, bus.r0_rvalid, bus.r1_rvalid, bus.rdata, bus.rsp_err,
                   mon_e.cyc, mon_e.id, mon_e.data, mon_e.err);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_rd(input logic id, input logic [14:0] a);
    exp_t e;
    e.id   = id;
    e.err  = oob(a);
    e.data = e.err ? 64'd0 : shadow[a];
    e.cyc  = cyc + 2;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered and left one time unit after a rising edge.
  task automatic r1_op(input logic we, input logic [14:0] a, input logic [63:0] d);
    bus.r1_req = 1'b1; bus.r1_we = we; bus.r1_addr = a; bus.r1_wdata = d;
    @(negedge clk);
    chk("r1_gnt", bus.r1_gnt, 1'b1);
    if (!we) push_rd(1'b1, a);
    else if (!oob(a)) shadow[a] = d;
    step();
    bus.r1_req = 1'b0;
    @(negedge clk);
    chk("r1_mem_dir", bus.mem_dir, a);
    chk("r1_mem_wr", bus.mem_write_flag, we && !oob(a));
    step();
  endtask

  task automatic r0_burst(input logic we, input logic [14:0] a0, input logic [2:0] len,
                          input logic [63:0] d0, output int waited);
    logic [14:0] a, pa;
    logic        pwe;
    bus.r0_req = 1'b1; bus.r0_we = we; bus.r0_addr = a0; bus.r0_len = len; bus.r0_wdata = d0;
    waited = 0;
    @(negedge clk);
    while (!bus.r0_gnt && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.r0_gnt) begin
      checks++;
      errors++;
      $display("FAIL r0_gnt_timeout: got no grant in 20 cycles, required a grant");
      bus.r0_req = 1'b0;
      step();
      return;
    end
    pa = a0; pwe = we;
    for (int b = 0; b <= int'(len); b++) begin
      a = a0 + 15'(b);
      chk("r0_beat", bus.r0_beat, 1'b1);
      if (b > 0) begin
        chk("r0_gnt_in_burst", bus.r0_gnt, 1'b0);
        chk("burst_mem_dir", bus.mem_dir, pa);
        chk("burst_mem_wr", bus.mem_write_flag, pwe && !oob(pa));
        if (pwe) chk("burst_mem_din", bus.mem_data_in, d0 + 64'(b - 1));
      end
      if (!we) push_rd(1'b0, a);
      else if (!oob(a)) shadow[a] = d0 + 64'(b);
      pa = a;
      step();
      bus.r0_req = 1'b0;
      bus.r0_wdata = d0 + 64'(b + 1);
      if (b < int'(len)) @(negedge clk);
    end
    @(negedge clk);
    chk("r0_beat_end", bus.r0_beat, 1'b0);
    chk("last_mem_dir", bus.mem_dir, pa);
    chk("last_mem_wr", bus.mem_write_flag, pwe && !oob(pa));
    step();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_r0_gnt"}, bus.r0_gnt, 1'b0);
    chk({tag, "_r1_gnt"}, bus.r1_gnt, 1'b0);
    chk({tag, "_r0_beat"}, bus.r0_beat, 1'b0);
    chk({tag, "_rvalid"}, {bus.r0_rvalid, bus.r1_rvalid, bus.rsp_err}, 3'b000);
    chk({tag, "_mem_wr"}, bus.mem_write_flag, 1'b0);
    chk({tag, "_mem_dir"}, bus.mem_dir, 15'd0);
    chk({tag, "_mem_din"}, bus.mem_data_in, 64'd0);
    chk({tag, "_rdata"}, bus.rdata, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst = 1'b1;
    bus.r0_req = 1'b0; bus.r0_we = 1'b0; bus.r0_addr = '0; bus.r0_len = '0; bus.r0_wdata = '0;
    bus.r1_req = 1'b0; bus.r1_we = 1'b0; bus.r1_addr = '0; bus.r1_wdata = '0;
    for (int i = 0; i < 32768; i++) shadow[i] = init_val(i);
    shadow[5] = 64'hA5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    chk("mem_file_enable", bus.mem_file_enable, 1'b0);
    step();
    rst = 1'b0;
    step();

    // Tie after reset: r0 (2 beats), then r1, then the second r0 request.
    bus.r0_req = 1'b1; bus.r0_we = 1'b0; bus.r0_addr = 15'h10; bus.r0_len = 3'd1;
    bus.r1_req = 1'b1; bus.r1_we = 1'b0; bus.r1_addr = 15'h20;
    @(negedge clk);
    chk("tie_r0_gnt", bus.r0_gnt, 1'b1);
    chk("tie_r1_gnt", bus.r1_gnt, 1'b0);
    push_rd(1'b0, 15'h10);
    step();
    bus.r0_addr = 15'h30; bus.r0_len = 3'd0;
    @(negedge clk);
    chk("burst_beat", bus.r0_beat, 1'b1);
    chk("burst_no_gnt", {bus.r0_gnt, bus.r1_gnt}, 2'b00);
    push_rd(1'b0, 15'h11);
    step();
    @(negedge clk);
    chk("after_r1_gnt", bus.r1_gnt, 1'b1);
    chk("after_r0_gnt", bus.r0_gnt, 1'b0);
    push_rd(1'b1, 15'h20);
    step();
    bus.r1_req = 1'b0;
    @(negedge clk);
    chk("regrant_r0_gnt", bus.r0_gnt, 1'b1);
    push_rd(1'b0, 15'h30);
    step();
    bus.r0_req = 1'b0;
    repeat (4) step();

    r1_op(1'b0, 15'd5, 64'd0);
    r1_op(1'b1, 15'h40, 64'h1234_5678);
    r1_op(1'b0, 15'h40, 64'd0);

    r0_burst(1'b1, 15'h100, 3'd3, 64'd1, w);
    r0_burst(1'b0, 15'h100, 3'd3, 64'd0, w);
    r0_burst(1'b0, 15'h7FFE, 3'd3, 64'd0, w);
    r0_burst(1'b0, 15'h300, 3'd7, 64'd0, w);
    repeat (4) step();

    // Reset during beat 2 of a 6-beat read; its responses must never appear.
    bus.r0_req = 1'b1; bus.r0_we = 1'b0; bus.r0_addr = 15'h200; bus.r0_len = 3'd5;
    @(negedge clk);
    chk("rstb_gnt", bus.r0_gnt, 1'b1);
    step();
    bus.r0_req = 1'b0;
    @(negedge clk);
    chk("rstb_beat1", bus.r0_beat, 1'b1);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midrst");
    step();
    rst = 1'b0;
    repeat (6) step();
    r0_burst(1'b0, 15'h200, 3'd0, 64'd0, w);
    chk("post_rst_wait", 64'(w), 64'd0);

    repeat (5) step();
    chk("scoreboard_drain", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
